// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg -- definitions shared by rc5_enc_16bit and rc5_dec_16bit.
//
// Contents:
//   RC5_W, RC5_ROUNDS, RC5_T  word size, round count, key table length
//   RC5_IW                    index width for the key table
//   rc5_word_t                one 8-bit RC5 half-block
//   RC5_S                     expanded key table; the encryptor and the
//                             decryptor must both use this copy
//   rc5_dec_state_e           decryptor FSM encoding (visible on dbg_state)
//   rc5_rotr                  8-bit rotate right by a 3-bit amount
// ---------------------------------------------------------------------------
package rc5_pkg;

  localparam int RC5_W      = 8;
  localparam int RC5_ROUNDS = 12;
  localparam int RC5_T      = 2 * RC5_ROUNDS + 2;
  localparam int RC5_IW     = $clog2(RC5_T);

  typedef logic [RC5_W-1:0] rc5_word_t;

  // Expanded key table (S[k] = 0xB7 + k*0x9F mod 256).
  localparam rc5_word_t RC5_S [RC5_T] = '{
    8'hB7, 8'h56, 8'hF5, 8'h94, 8'h33, 8'hD2, 8'h71, 8'h10,
    8'hAF, 8'h4E, 8'hED, 8'h8C, 8'h2B, 8'hCA, 8'h69, 8'h08,
    8'hA7, 8'h46, 8'hE5, 8'h84, 8'h23, 8'hC2, 8'h61, 8'h00,
    8'h9F, 8'h3E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } rc5_dec_state_e;

  // Rotating the doubled word right leaves the rotated byte in the low half;
  // an amount of 0 returns x unchanged.
  function automatic rc5_word_t rc5_rotr(rc5_word_t x, logic [2:0] n);
    logic [2*RC5_W-1:0] d;
    d = {x, x} >> n;
    return d[RC5_W-1:0];
  endfunction

endpackage

// File: rtl/rc5_dec_round.sv
// ---------------------------------------------------------------------------
// rc5_dec_round -- one combinational inverse RC5 round.
//
// Ports:
//   a, b      in   current halves (A, B)
//   s_even    in   S[2i]
//   s_odd     in   S[2i+1]
//   a_n, b_n  out  halves after undoing round i
//
// B is recovered first because the A step rotates by the recovered B.
// ---------------------------------------------------------------------------
module rc5_dec_round
  import rc5_pkg::*;
(
  input  rc5_word_t a,
  input  rc5_word_t b,
  input  rc5_word_t s_even,
  input  rc5_word_t s_odd,
  output rc5_word_t a_n,
  output rc5_word_t b_n
);

  rc5_word_t b_sub;
  rc5_word_t a_sub;

  assign b_sub = b - s_odd;
  assign b_n   = rc5_rotr(b_sub, a[2:0]) ^ a;
  assign a_sub = a - s_even;
  assign a_n   = rc5_rotr(a_sub, b_n[2:0]) ^ b_n;

endmodule

// File: rtl/rc5_dec_16bit.sv
// ---------------------------------------------------------------------------
// rc5_dec_16bit -- iterative RC5-8/ROUNDS block decryptor, 16-bit block.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   dec_start  in   request, sampled only in IDLE
//   c[15:0]    in   ciphertext, c[7:0]=A, c[15:8]=B, captured on acceptance
//   p[15:0]    out  plaintext, registered, holds until the next result
//   dec_busy   out  high while a block is in flight (ROUND, FINAL)
//   dec_done   out  one-cycle pulse, p valid from this cycle on
//   dbg_state  out  current FSM state
//
// Handshake: a block is accepted on any rising edge where dec_start=1 and
// the FSM is in IDLE (dec_busy=0); c is captured on that edge only. Starts
// while busy are dropped. dec_done pulses for one cycle with the FSM already
// back in IDLE, so a held dec_start is accepted on the following edge.
//
// Build option RC5_DEC_UNROLL2_EN: two rounds per ROUND edge (needs even
// ROUNDS), latency ROUNDS/2+2 edges instead of ROUNDS+2.
// ---------------------------------------------------------------------------
module rc5_dec_16bit
  import rc5_pkg::*;
#(
  parameter int ROUNDS = RC5_ROUNDS
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           dec_start,
  input  logic [15:0]    c,
  output logic [15:0]    p,
  output logic           dec_busy,
  output logic           dec_done,
  output rc5_dec_state_e dbg_state
);

  localparam int CW = $clog2(ROUNDS + 1);

  if (ROUNDS < 1 || ROUNDS > RC5_ROUNDS) begin : g_bad_rounds
    $error("rc5_dec_16bit: ROUNDS must be in 1..RC5_ROUNDS");
  end

  rc5_dec_state_e  state;
  rc5_dec_state_e  state_nx;
  rc5_word_t       a_q;
  rc5_word_t       b_q;
  logic [CW-1:0]   rnd_i;
  rc5_word_t       a_nx;
  rc5_word_t       b_nx;

  // Key indices for round i: 2i and 2i+1.
  logic [RC5_IW-1:0] k_hi_even;
  logic [RC5_IW-1:0] k_hi_odd;
  rc5_word_t         a_r1;
  rc5_word_t         b_r1;

  assign k_hi_even = RC5_IW'(rnd_i) << 1;
  assign k_hi_odd  = {k_hi_even[RC5_IW-1:1], 1'b1};

  rc5_dec_round u_round_hi (
    .a      (a_q),
    .b      (b_q),
    .s_even (RC5_S[k_hi_even]),
    .s_odd  (RC5_S[k_hi_odd]),
    .a_n    (a_r1),
    .b_n    (b_r1)
  );

`ifdef RC5_DEC_UNROLL2_EN
  localparam int STEP = 2;

  if ((ROUNDS % 2) != 0) begin : g_odd_rounds
    $error("rc5_dec_16bit: RC5_DEC_UNROLL2_EN needs an even ROUNDS");
  end

  // Second stage undoes round i-1 in the same cycle.
  logic [RC5_IW-1:0] k_lo_even;
  logic [RC5_IW-1:0] k_lo_odd;
  rc5_word_t         a_r2;
  rc5_word_t         b_r2;

  assign k_lo_even = k_hi_even - RC5_IW'(2);
  assign k_lo_odd  = {k_lo_even[RC5_IW-1:1], 1'b1};

  rc5_dec_round u_round_lo (
    .a      (a_r1),
    .b      (b_r1),
    .s_even (RC5_S[k_lo_even]),
    .s_odd  (RC5_S[k_lo_odd]),
    .a_n    (a_r2),
    .b_n    (b_r2)
  );

  assign a_nx = a_r2;
  assign b_nx = b_r2;
`else
  localparam int STEP = 1;

  assign a_nx = a_r1;
  assign b_nx = b_r1;
`endif

  // The counter drops by STEP per ROUND edge; the edge that sees i==STEP
  // applies the last rounds and moves on to FINAL.
  localparam logic [CW-1:0] I_STEP  = CW'(STEP);
  localparam logic [CW-1:0] I_START = CW'(ROUNDS);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (dec_start)        state_nx = ST_ROUND;
      ST_ROUND: if (rnd_i == I_STEP)  state_nx = ST_FINAL;
      ST_FINAL:                       state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    dec_busy = 1'b0;
    case (state)
      ST_ROUND, ST_FINAL: dec_busy = 1'b1;
      default:            dec_busy = 1'b0;
    endcase
  end

  assign dbg_state = state;

  // Datapath: half-block registers, round counter, result and done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      rnd_i    <= '0;
      p        <= '0;
      dec_done <= 1'b0;
    end else begin
      dec_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dec_start) begin
            a_q   <= c[7:0];
            b_q   <= c[15:8];
            rnd_i <= I_START;
          end
        end
        ST_ROUND: begin
          a_q   <= a_nx;
          b_q   <= b_nx;
          rnd_i <= rnd_i - I_STEP;
        end
        ST_FINAL: begin
          // Undo the pre-whitening with S[0], S[1].
          p        <= {b_q - RC5_S[1], a_q - RC5_S[0]};
          dec_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// ---------------------------------------------------------------------------
// tb_rc5_dec_16bit -- self-checking bench for rc5_dec_16bit.
//
// Ciphertexts come from a bench-side RC5 encryptor model with its own copy
// of the key table, so dec(enc(pt)) must return the plaintext pt that the
// bench chose. Build with RC5_DEC_UNROLL2_EN to check the two-round variant.
// ---------------------------------------------------------------------------
module tb_rc5_dec_16bit;
  import rc5_pkg::*;

`ifdef RC5_DEC_UNROLL2_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 14;
`endif

  localparam logic [7:0] TB_S [26] = '{
    8'hB7, 8'h56, 8'hF5, 8'h94, 8'h33, 8'hD2, 8'h71, 8'h10,
    8'hAF, 8'h4E, 8'hED, 8'h8C, 8'h2B, 8'hCA, 8'h69, 8'h08,
    8'hA7, 8'h46, 8'hE5, 8'h84, 8'h23, 8'hC2, 8'h61, 8'h00,
    8'h9F, 8'h3E
  };

  logic           clock = 1'b0;
  logic           reset;
  logic           dec_start;
  logic [15:0]    c;
  logic [15:0]    p;
  logic           dec_busy;
  logic           dec_done;
  rc5_dec_state_e dbg_state;

  logic [15:0] exp_q[$];
  logic [15:0] last_pt;
  int          n_tests = 0;
  int          n_fail  = 0;

  rc5_dec_16bit u_dut (
    .clock     (clock),
    .reset     (reset),
    .dec_start (dec_start),
    .c         (c),
    .p         (p),
    .dec_busy  (dec_busy),
    .dec_done  (dec_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [15:0] enc_model(input logic [15:0] pt);
    logic [7:0] a;
    logic [7:0] b;
    a = pt[7:0]  + TB_S[0];
    b = pt[15:8] + TB_S[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl8(a ^ b, b[2:0]) + TB_S[2*r];
      b = rotl8(b ^ a, a[2:0]) + TB_S[2*r+1];
    end
    return {b, a};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every dec_done pops one expected plaintext.
  always @(negedge clock) begin
    if (reset === 1'b1 && dec_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(exp_q.size()), 32'd1);
      end else begin
        check("p", {16'h0, p}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  // One block; disturb_at>0 drives c=0 with a one-cycle dec_start after that edge.
  task automatic dec_one(input logic [15:0] pt, input int disturb_at);
    int n;
    int busy_n;
    bit seen;
    @(negedge clock);
    c         = enc_model(pt);
    dec_start = 1'b1;
    exp_q.push_back(pt);
    @(posedge clock);
    #1;
    dec_start = 1'b0;
    check("p_hold", {16'h0, p}, {16'h0, last_pt});
    n      = 1;
    busy_n = int'(dec_busy);
    seen   = 1'b0;
    while (!seen && n < LAT + 10) begin
      @(posedge clock);
      #1;
      n++;
      if (dec_done) seen = 1'b1;
      else          busy_n += int'(dec_busy);
      if (n == disturb_at) begin
        c         = 16'h0000;
        dec_start = 1'b1;
      end else if (disturb_at > 0 && n == disturb_at + 1) begin
        dec_start = 1'b0;
      end
    end
    dec_start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), 32'(LAT));
    check("busy_cycles", 32'(busy_n), 32'(LAT - 1));
    check("busy_at_done", 32'(dec_busy), 32'd0);
    last_pt = pt;
  endtask

  // Two blocks with dec_start held high throughout.
  task automatic dec_b2b(input logic [15:0] pt1, input logic [15:0] pt2);
    int n;
    int d1;
    int d2;
    int dones;
    @(negedge clock);
    c         = enc_model(pt1);
    dec_start = 1'b1;
    exp_q.push_back(pt1);
    exp_q.push_back(pt2);
    @(posedge clock);
    #1;
    c     = enc_model(pt2);
    n     = 1;
    d1    = 0;
    d2    = 0;
    dones = 0;
    while (dones < 2 && n < 2 * LAT + 10) begin
      @(posedge clock);
      #1;
      n++;
      if (n == LAT + 1) dec_start = 1'b0;
      if (dec_done) begin
        dones++;
        if (dones == 1) d1 = n;
        else            d2 = n;
      end
    end
    dec_start = 1'b0;
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_first_done", 32'(d1), 32'(LAT));
    check("b2b_second_done", 32'(d2), 32'(2 * LAT));
    last_pt = pt2;
  endtask

  // Reset asserted between edges six cycles into a block.
  task automatic abort_block();
    @(negedge clock);
    c         = enc_model(16'h1234);
    dec_start = 1'b1;
    @(posedge clock);
    #1;
    dec_start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_p", {16'h0, p}, 32'h0);
    check("abort_busy", 32'(dec_busy), 32'd0);
    check("abort_done", 32'(dec_done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    last_pt = 16'h0000;
    repeat (LAT + 4) @(negedge clock);
    check("abort_no_done_busy", 32'(dec_busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    dec_start = 1'b0;
    c         = 16'h0000;
    last_pt   = 16'h0000;
    repeat (3) @(negedge clock);
    check("rst_p", {16'h0, p}, 32'h0);
    check("rst_busy", 32'(dec_busy), 32'd0);
    check("rst_done", 32'(dec_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;

    dec_one(16'hFFFF, 0);
    dec_b2b(16'hFF00, 16'h00FF);
    dec_one(16'h0000, 0);
    dec_one(16'hAAAA, 0);
    dec_one(16'h5555, 0);
    // Late c change plus a stray start while busy: result must be unaffected.
    dec_one(16'hFFFF, 6);
    repeat (LAT + 2) @(negedge clock);
    check("stray_start_idle", 32'(dbg_state), 32'(ST_IDLE));

    abort_block();
    dec_one(16'hC3A5, 0);

    for (int k = 0; k < 200; k++) begin
      dec_one(16'($urandom_range(0, 65535)), 0);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
